// File: rtl/ones_count_pkg.sv
// Shared constants and types for the ones counter / ones pattern serializer pair.
package ones_count_pkg;

  localparam int FRAME_LEN = 15;
  localparam int CNT_W     = 4;
  localparam int IDX_W     = 4;

  localparam logic MODE_PACKED = 1'b0;
  localparam logic MODE_SPREAD = 1'b1;

  // Frame length at accumulator-sum width, and index of the final frame bit.
  localparam logic [CNT_W:0]   FRAME_LEN_S = 5'd15;
  localparam logic [IDX_W-1:0] LAST_IDX    = 4'd14;

  typedef enum logic {IDLE, SEND} state_t;

endpackage

// File: rtl/ones_pattern_gen.sv
// Combinational bit generator: decides the frame bit at position idx and the
// next distribution accumulator value.
module ones_pattern_gen
  import ones_count_pkg::*;
(
  input  logic [CNT_W-1:0] count,
  input  logic             mode,
  input  logic [IDX_W-1:0] idx,
  input  logic [CNT_W-1:0] acc,
  output logic             bit_out,
  output logic [CNT_W-1:0] acc_next
);

  logic [CNT_W:0] sum;
  logic [CNT_W:0] wrapped;

  // Packed: ones occupy the low indices. Spread: Bresenham-style accumulator,
  // acc stays in 0..14 because sum never exceeds 14 + 15.
  always_comb begin
    sum      = {1'b0, acc} + {1'b0, count};
    wrapped  = sum - FRAME_LEN_S;
    bit_out  = 1'b0;
    acc_next = acc;
    if (mode == MODE_SPREAD) begin
      bit_out  = (sum >= FRAME_LEN_S);
      acc_next = bit_out ? wrapped[CNT_W-1:0] : sum[CNT_W-1:0];
    end else begin
      bit_out  = (idx < count);
    end
  end

endmodule

// File: rtl/ones_pattern_serializer.sv
// Serializes a 15-bit frame holding exactly in_count ones, packed or spread,
// and republishes each completed frame in parallel on frame_out.
module ones_pattern_serializer
  import ones_count_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [CNT_W-1:0]     in_count,
  input  logic                 in_mode,
  output logic                 in_ready,
  output logic                 ser_valid,
  input  logic                 ser_ready,
  output logic                 ser_bit,
  output logic                 ser_first,
  output logic                 ser_last,
  output logic                 frame_done,
  output logic [FRAME_LEN-1:0] frame_out
);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     count_q;
  logic                 mode_q;
  logic [IDX_W-1:0]     idx;
  logic [CNT_W-1:0]     acc;
  logic [CNT_W-1:0]     acc_nxt;
  logic [FRAME_LEN-1:0] shadow;
  logic                 gen_bit;
  logic                 at_last;
  logic                 beat;
  logic                 last_beat;
  logic                 accept;

  ones_pattern_gen u_gen (
    .count    (count_q),
    .mode     (mode_q),
    .idx      (idx),
    .acc      (acc),
    .bit_out  (gen_bit),
    .acc_next (acc_nxt)
  );

  assign at_last   = (idx == LAST_IDX);
  assign beat      = ser_valid & ser_ready;
  assign last_beat = beat & at_last;
  assign accept    = in_valid & in_ready;

  // Serial outputs decode registered state only; ser_ready never reaches ser_bit.
  assign ser_bit   = ser_valid & gen_bit;
  assign ser_first = ser_valid & (idx == '0);
  assign ser_last  = ser_valid & at_last;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake; the final beat may chain straight into a new frame.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SEND;
      end
      SEND: begin
        ser_valid = 1'b1;
        in_ready  = ser_ready & at_last;
        if (last_beat) state_nxt = in_valid ? SEND : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture and per-beat index / accumulator advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      mode_q  <= MODE_PACKED;
      idx     <= '0;
      acc     <= '0;
    end else if (accept) begin
      count_q <= in_count;
      mode_q  <= in_mode;
      idx     <= '0;
      acc     <= '0;
    end else if (beat) begin
      idx     <= idx + 1'b1;
      acc     <= acc_nxt;
    end
  end

  // Frame shadow collects accepted bits; the final beat publishes the whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow     <= '0;
      frame_out  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_beat;
      if (beat)      shadow[idx] <= gen_bit;
      if (last_beat) frame_out   <= {gen_bit, shadow[FRAME_LEN-2:0]};
    end
  end

endmodule
